// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

  localparam int unsigned CREDIT_W   = 5;
  localparam int unsigned CREDIT_MAX = 31;

  // coin_type encodings
  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDispense,
    StChange
  } vend_state_e;

  // Face value in NIS of an encoded coin.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] ct);
    logic [CREDIT_W-1:0] val;
    unique case (ct)
      COIN_1:  val = 5'd1;
      COIN_2:  val = 5'd2;
      COIN_5:  val = 5'd5;
      default: val = 5'd10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: picks the largest coin not exceeding the credit.
module vend_change_sel
  import vend_pkg::*;
(
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] chg_value
);

  // Largest-first coin pick; zero credit yields a zero value.
  always_comb begin
    chg_coin  = COIN_1;
    chg_value = '0;
    if (credit >= 5'd10) begin
      chg_coin  = COIN_10;
      chg_value = 5'd10;
    end else if (credit >= 5'd5) begin
      chg_coin  = COIN_5;
      chg_value = 5'd5;
    end else if (credit >= 5'd2) begin
      chg_coin  = COIN_2;
      chg_value = 5'd2;
    end else if (credit != '0) begin
      chg_coin  = COIN_1;
      chg_value = 5'd1;
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit accumulator FSM: collects coins, sells items, returns change.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0 = 5,
  parameter int unsigned PRICE1 = 8,
  parameter int unsigned PRICE2 = 12,
  parameter int unsigned PRICE3 = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  input  logic                disp_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                disp_valid,
  output logic [1:0]          disp_item,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic                busy
);

  if (PRICE0 < 1 || PRICE0 > CREDIT_MAX || PRICE1 < 1 || PRICE1 > CREDIT_MAX ||
      PRICE2 < 1 || PRICE2 > CREDIT_MAX || PRICE3 < 1 || PRICE3 > CREDIT_MAX) begin : g_bad_price
    $error("vend_credit_ctrl: every PRICEn must lie in 1..31");
  end

  localparam logic [CREDIT_W-1:0] Price0 = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] Price1 = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] Price2 = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] Price3 = CREDIT_W'(PRICE3);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          disp_item_q, disp_item_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   sum;
  logic [1:0]          sel_coin;
  logic [CREDIT_W-1:0] sel_value;

  vend_change_sel u_change_sel (
    .credit    (credit_q),
    .chg_coin  (sel_coin),
    .chg_value (sel_value)
  );

  // Price lookup for the requested item.
  always_comb begin
    price = Price0;
    unique case (sel_item)
      2'd0:    price = Price0;
      2'd1:    price = Price1;
      2'd2:    price = Price2;
      default: price = Price3;
    endcase
  end

  // Next-state, credit update and one-cycle status pulses.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    disp_item_d    = disp_item_q;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    // Widened so a 31 + 10 overflow is visible instead of wrapping.
    sum            = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};

    unique case (state_q)
      StIdle, StCollect: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          if (state_q == StCollect) state_d = StChange;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (credit_q >= price) begin
            credit_d    = credit_q - price;
            disp_item_d = sel_item;
            state_d     = StDispense;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (sum <= (CREDIT_W + 1)'(CREDIT_MAX)) begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = StCollect;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      StDispense: begin
        coin_reject_d = coin_valid;
        if (disp_ready) state_d = (credit_q != '0) ? StChange : StIdle;
      end
      StChange: begin
        coin_reject_d = coin_valid;
        credit_d      = credit_q - sel_value;
        if (credit_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any in-flight sale or refund.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      disp_item_q    <= 2'd0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      disp_item_q    <= disp_item_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign disp_valid   = (state_q == StDispense);
  assign disp_item    = disp_item_q;
  assign chg_valid    = (state_q == StChange) && (credit_q != '0);
  assign chg_coin     = chg_valid ? sel_coin : 2'b00;
  assign busy         = (state_q == StDispense) || (state_q == StChange);

endmodule
